// File: rtl/scan_sel_gen.sv
// -----------------------------------------------------------------------------
// scan_sel_gen
// Round-robin select generator for a downstream 2-to-4 decoder. After a start
// request it walks the enabled channels in ascending order, holding the decoder
// enable for a programmable dwell on each channel. A one-cycle blanking gap
// separates channels so the decoder breaks before it makes.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a scan when sampled high in IDLE
//   stop       in   abort the scan when sampled high in DWELL or GAP
//   chan_mask  in   [3:0] channel enable mask, captured at start
//   dwell      in   [DWELL_W-1:0] enable cycles per channel (0 acts as 1)
//   sel        out  [1:0] registered channel index
//   en         out  registered decoder enable
//   busy       out  high in every state except IDLE
//   wrap       out  one-cycle pulse when a full pass over the channels completes
//   err        out  one-cycle pulse when a start is rejected for an empty mask
// -----------------------------------------------------------------------------
module scan_sel_gen #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               wrap,
    output logic               err
);

    localparam int unsigned NCHAN = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [NCHAN-1:0]   mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;

    // Next enabled channel strictly after cur, searching upward and wrapping.
    // Starting from channel 3 this yields the lowest set bit of the mask.
    function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] cur,
                                                   input logic [NCHAN-1:0] m);
        logic [SEL_W-1:0] r;
        logic [SEL_W-1:0] idx;
        logic             found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= NCHAN; i++) begin
            idx = SEL_W'(int'(cur) + i);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Dwell of zero is stretched to a single cycle.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    // Scan sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            dwell_q <= '0;
            cnt     <= '0;
            sel     <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-armed below.
            wrap <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                    // stop outranks start, so a simultaneous pair is a no-op.
                    if (start && !stop) begin
                        if (chan_mask == '0) begin
                            err <= 1'b1;
                        end else begin
                            mask_q  <= chan_mask;
                            dwell_q <= dwell;
                            cnt     <= dwell_load(dwell);
                            sel     <= next_chan(SEL_W'(NCHAN - 1), chan_mask);
                            en      <= 1'b1;
                            busy    <= 1'b1;
                            state   <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt <= DWELL_W'(1)) begin
                        // Last enable cycle: blank and move to the next channel.
                        en    <= 1'b0;
                        sel   <= next_chan(sel, mask_q);
                        wrap  <= (next_chan(sel, mask_q) <= sel);
                        state <= GAP;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                GAP: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        en    <= 1'b1;
                        cnt   <= dwell_load(dwell_q);
                        state <= DWELL;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// -----------------------------------------------------------------------------
// tb_scan_sel_gen
// Directed and random stimulus for scan_sel_gen. Expected outputs come from a
// reference model that expands each scan pass into a queue of per-cycle
// (sel, en, wrap) triples from the channel list and dwell length.
// -----------------------------------------------------------------------------
module tb_scan_sel_gen;

    localparam int unsigned DWELL_W = 8;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic [3:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
    logic               en;
    logic               busy;
    logic               wrap;
    logic               err;

    scan_sel_gen #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .chan_mask (chan_mask),
        .dwell     (dwell),
        .sel       (sel),
        .en        (en),
        .busy      (busy),
        .wrap      (wrap),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       wrap;
    } exp_t;

    exp_t       q[$];
    logic       m_busy;
    logic [1:0] m_sel;
    logic       m_en;
    logic       m_wrap;
    logic       m_err;
    logic [3:0] m_mask;
    int         m_dwell;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, stepno, obs, exp);
        end
    endtask

    // One full pass: each enabled channel dwells, then a gap showing the next one.
    task automatic refill();
        int chans[$];
        int n;
        int nxt;
        exp_t e;
        for (int i = 0; i < 4; i++) if (m_mask[i]) chans.push_back(i);
        n = chans.size();
        for (int k = 0; k < n; k++) begin
            for (int d = 0; d < m_dwell; d++) begin
                e.sel = 2'(chans[k]); e.en = 1'b1; e.wrap = 1'b0;
                q.push_back(e);
            end
            nxt = chans[(k + 1) % n];
            e.sel = 2'(nxt); e.en = 1'b0; e.wrap = (nxt <= chans[k]);
            q.push_back(e);
        end
    endtask

    task automatic pop_exp();
        exp_t e;
        if (q.size() == 0) refill();
        e = q.pop_front();
        m_sel  = e.sel;
        m_en   = e.en;
        m_wrap = e.wrap;
    endtask

    // Reference behaviour for one rising edge with the current inputs.
    task automatic model_edge();
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_sel = 2'd0; m_en = 1'b0; m_mask = 4'd0; m_dwell = 1;
            q.delete();
        end else if (!m_busy) begin
            if (start && !stop) begin
                if (chan_mask == 4'd0) begin
                    m_err = 1'b1;
                end else begin
                    m_mask  = chan_mask;
                    m_dwell = (dwell == 0) ? 1 : int'(dwell);
                    m_busy  = 1'b1;
                    q.delete();
                    pop_exp();
                end
            end
        end else if (stop) begin
            m_busy = 1'b0;
            m_en   = 1'b0;
            q.delete();
        end else begin
            pop_exp();
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        stepno++;
        check("sel",  8'(sel),  8'(m_sel));
        check("en",   8'(en),   8'(m_en));
        check("busy", 8'(busy), 8'(m_busy));
        check("wrap", 8'(wrap), 8'(m_wrap));
        check("err",  8'(err),  8'(m_err));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Fixed sel/en/wrap sequence for mask 1011, dwell 2, independent of the model.
    logic [1:0] g_sel [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    logic       g_en  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       g_wr  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        m_busy = 1'b0; m_sel = 2'd0; m_en = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        m_mask = 4'd0; m_dwell = 1;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; chan_mask = 4'd0; dwell = '0;

        // Reset state.
        steps(2);
        rst_n = 1'b1;
        steps(2);

        // Mask 1011, dwell 2: golden sequence plus model.
        chan_mask = 4'b1011; dwell = 8'd2; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            start = 1'b0;
            check("gold_sel",  8'(sel),  8'(g_sel[i]));
            check("gold_en",   8'(en),   8'(g_en[i]));
            check("gold_wrap", 8'(wrap), 8'(g_wr[i]));
        end
        steps(5);
        stop = 1'b1; step(); stop = 1'b0;
        steps(2);

        // Single channel 2, dwell 0.
        chan_mask = 4'b0100; dwell = 8'd0; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("single_sel", 8'(sel), 8'd2);
            check("single_wrap_on_gap", 8'(wrap), 8'(!en));
        end
        stop = 1'b1; step(); stop = 1'b0;

        // Empty mask start rejected.
        chan_mask = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        check("err_pulse", 8'(err), 8'd1);
        steps(3);

        // Start and stop together in IDLE.
        chan_mask = 4'b0001; start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 8'(busy), 8'd0);

        // Stop on the second dwell cycle of channel 1.
        chan_mask = 4'b1011; dwell = 8'd2; start = 1'b1;
        step(); start = 1'b0;
        steps(4);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_sel_hold", 8'(sel), 8'd1);
        steps(3);

        // Reset in the gap, then restart from channel 0.
        chan_mask = 4'b1111; dwell = 8'd3; start = 1'b1;
        step(); start = 1'b0;
        steps(3);
        check("in_gap_en", 8'(en), 8'd0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        check("restart_sel", 8'(sel), 8'd0);
        stop = 1'b1; step(); stop = 1'b0;

        // Mask and dwell changes while busy are ignored; restart mid-scan ignored.
        chan_mask = 4'b0011; dwell = 8'd1; start = 1'b1;
        step(); start = 1'b0;
        chan_mask = 4'b1100; dwell = 8'd5;
        for (int i = 0; i < 12; i++) begin
            start = (i == 5);
            step();
            check("captured_mask", 8'(sel < 2'd2), 8'd1);
        end
        start = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            chan_mask = 4'($urandom_range(0, 15));
            dwell     = DWELL_W'($urandom_range(0, 4));
            start     = ($urandom_range(0, 9) < 3);
            stop      = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
